seat_scan_reader: RTL and testbench

- Read-side companion to the seat table memory, which holds an 11-bit time stamp and a 2-bit state per seat.
- On request, sweeps every seat over a synchronous read port and classifies each seat, including reservation-timeout evaluation.
- Publishes occupancy counts and the lowest-numbered free seat to the kiosk/display controller.

---
 rtl/seat_pkg.sv | 24 ++
 rtl/seat_expire_chk.sv | 19 +
 rtl/seat_scan_reader.sv | 181 ++++++++++++++++++
 tb/tb_seat_scan_reader.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seat_pkg.sv
// Shared definitions for the seat table read side (scan reader) and the
// write-side timeout logic: table geometry, seat state encoding, scan FSM states.
package seat_pkg;

    localparam int N_SEATS = 32;
    localparam int TIME_W  = 11;
    localparam int SEAT_W  = 8;
    localparam int CNT_W   = $clog2(N_SEATS + 1);

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        RESERVED = 2'd1,
        AWAY     = 2'd2,
        OCCUPIED = 2'd3
    } seat_state_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } scan_state_t;

endpackage

// File: rtl/seat_expire_chk.sv
// Reservation timeout test shared by the read and write sides of the seat
// table. Elapsed time is taken modulo 2^TIME_W so a stamp from before the
// time counter wrapped still yields the true distance; the timeout is strict.
module seat_expire_chk
    import seat_pkg::*;
(
    input  logic [TIME_W-1:0] now,
    input  logic [TIME_W-1:0] stamp,
    input  logic [TIME_W-1:0] limit,
    input  seat_state_t       state,
    output logic              expired
);

    logic [TIME_W-1:0] elapsed;

    assign elapsed = now - stamp;
    assign expired = (state == RESERVED) && (elapsed > limit);

endmodule

// File: rtl/seat_scan_reader.sv
// Seat table scanner: sweeps all seats over the synchronous read port,
// classifies each one (with reservation timeout) and publishes occupancy
// counts plus the lowest free seat when the sweep completes.
// Optional macro SEAT_SCAN_EXPIRE_CLR_EN adds clr_en/clr_addr, a one-cycle
// strobe per expired seat so the write port can return it to FREE.
module seat_scan_reader
    import seat_pkg::*;
(
    input  logic              clk_scan,
    input  logic              rst_scan,
    input  logic              start_scan,
    input  logic [TIME_W-1:0] Time_now,
    input  logic [TIME_W-1:0] limit_time,
    output logic              rd_en,
    output logic [SEAT_W-1:0] rd_addr,
    input  logic [TIME_W-1:0] rd_time,
    input  logic [1:0]        rd_state,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  free_cnt,
    output logic [CNT_W-1:0]  reserved_cnt,
    output logic [CNT_W-1:0]  occupied_cnt,
    output logic [CNT_W-1:0]  expired_cnt,
    output logic [SEAT_W-1:0] first_free,
    output logic              first_free_vld
`ifdef SEAT_SCAN_EXPIRE_CLR_EN
    ,
    output logic              clr_en,
    output logic [SEAT_W-1:0] clr_addr
`endif
);

    scan_state_t       state;
    logic [SEAT_W-1:0] addr_cnt;
    logic              last_addr;
    logic              start_acc;

    logic [TIME_W-1:0] time_snap;
    logic [TIME_W-1:0] limit_snap;

    logic              eval_vld_p1;
    logic [SEAT_W-1:0] eval_addr_p1;

    seat_state_t       seat;
    logic              expired;
    logic              is_free, is_res, is_occ, is_exp;

    logic [CNT_W-1:0]  free_acc, res_acc, occ_acc, exp_acc;
    logic [SEAT_W-1:0] ff_acc;
    logic              ff_vld_acc;
    logic [CNT_W-1:0]  free_nxt, res_nxt, occ_nxt, exp_nxt;
    logic [SEAT_W-1:0] ff_nxt;
    logic              ff_vld_nxt;

    assign last_addr = (addr_cnt == SEAT_W'(N_SEATS - 1));
    assign start_acc = (state == S_IDLE) && start_scan;
    assign rd_en     = (state == S_READ);
    assign rd_addr   = addr_cnt;
    assign busy      = (state == S_READ) || (state == S_DRAIN);
    assign done      = (state == S_DONE);

    // Scan sequencer: IDLE -> READ (one address per cycle) -> DRAIN -> DONE
    always_ff @(posedge clk_scan) begin
        if (rst_scan) begin
            state    <= S_IDLE;
            addr_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_scan) begin
                        state    <= S_READ;
                        addr_cnt <= '0;
                    end
                end
                S_READ: begin
                    if (last_addr) begin
                        state    <= S_DRAIN;
                        addr_cnt <= '0;
                    end else begin
                        addr_cnt <= addr_cnt + SEAT_W'(1);
                    end
                end
                S_DRAIN: state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Freeze the time reference for the whole sweep
    always_ff @(posedge clk_scan) begin
        if (start_acc) begin
            time_snap  <= Time_now;
            limit_snap <= limit_time;
        end
    end

    // Read data returns one cycle after the strobe; track which seat it belongs to
    always_ff @(posedge clk_scan) begin
        if (rst_scan) begin
            eval_vld_p1 <= 1'b0;
        end else begin
            eval_vld_p1 <= rd_en;
        end
        eval_addr_p1 <= rd_addr;
    end

    // ---- stage p1: classify the returned seat ----
    assign seat = seat_state_t'(rd_state);

    seat_expire_chk u_expire_chk (
        .now     (time_snap),
        .stamp   (rd_time),
        .limit   (limit_snap),
        .state   (seat),
        .expired (expired)
    );

    assign is_exp  = eval_vld_p1 && expired;
    assign is_free = eval_vld_p1 && ((seat == FREE) || expired);
    assign is_res  = eval_vld_p1 && (seat == RESERVED) && !expired;
    assign is_occ  = eval_vld_p1 && ((seat == AWAY) || (seat == OCCUPIED));

    assign free_nxt   = free_acc + CNT_W'(is_free);
    assign res_nxt    = res_acc  + CNT_W'(is_res);
    assign occ_nxt    = occ_acc  + CNT_W'(is_occ);
    assign exp_nxt    = exp_acc  + CNT_W'(is_exp);
    assign ff_vld_nxt = ff_vld_acc || is_free;
    assign ff_nxt     = (is_free && !ff_vld_acc) ? eval_addr_p1 : ff_acc;

    // Running totals for the sweep; first free seat is latched once
    always_ff @(posedge clk_scan) begin
        if (rst_scan || start_acc) begin
            free_acc   <= '0;
            res_acc    <= '0;
            occ_acc    <= '0;
            exp_acc    <= '0;
            ff_acc     <= '0;
            ff_vld_acc <= 1'b0;
        end else if (eval_vld_p1) begin
            free_acc   <= free_nxt;
            res_acc    <= res_nxt;
            occ_acc    <= occ_nxt;
            exp_acc    <= exp_nxt;
            ff_acc     <= ff_nxt;
            ff_vld_acc <= ff_vld_nxt;
        end
    end

    // ---- stage p2: publish results entering DONE, including the last seat ----
    always_ff @(posedge clk_scan) begin
        if (rst_scan) begin
            free_cnt       <= '0;
            reserved_cnt   <= '0;
            occupied_cnt   <= '0;
            expired_cnt    <= '0;
            first_free     <= '0;
            first_free_vld <= 1'b0;
        end else if (state == S_DRAIN) begin
            free_cnt       <= free_nxt;
            reserved_cnt   <= res_nxt;
            occupied_cnt   <= occ_nxt;
            expired_cnt    <= exp_nxt;
            first_free     <= ff_nxt;
            first_free_vld <= ff_vld_nxt;
        end
    end

`ifdef SEAT_SCAN_EXPIRE_CLR_EN
    // One-cycle clear strobe for each seat found expired
    always_ff @(posedge clk_scan) begin
        if (rst_scan) begin
            clr_en   <= 1'b0;
            clr_addr <= '0;
        end else begin
            clr_en   <= is_exp;
            clr_addr <= eval_addr_p1;
        end
    end
`endif

endmodule

// File: tb/tb_seat_scan_reader.sv
// Directed bench for seat_scan_reader with a registered seat table model.
// Cycle c of a scan is the c-th clock period after the edge that samples start_scan.
module tb_seat_scan_reader;
    import seat_pkg::*;

    logic              clk_scan = 1'b0;
    logic              rst_scan;
    logic              start_scan;
    logic [TIME_W-1:0] Time_now;
    logic [TIME_W-1:0] limit_time;
    logic              rd_en;
    logic [SEAT_W-1:0] rd_addr;
    logic [TIME_W-1:0] rd_time;
    logic [1:0]        rd_state;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  free_cnt, reserved_cnt, occupied_cnt, expired_cnt;
    logic [SEAT_W-1:0] first_free;
    logic              first_free_vld;
`ifdef SEAT_SCAN_EXPIRE_CLR_EN
    logic              clr_en;
    logic [SEAT_W-1:0] clr_addr;
`endif

    int errors = 0;
    int checks = 0;

    logic [TIME_W-1:0] mem_time  [0:N_SEATS-1];
    logic [1:0]        mem_state [0:N_SEATS-1];

    localparam int NCYC = 45;
    logic              rec_rden [0:NCYC];
    logic              rec_busy [0:NCYC];
    logic              rec_done [0:NCYC];
    logic              rec_clr  [0:NCYC];
    logic [SEAT_W-1:0] rec_addr [0:NCYC];
    logic [SEAT_W-1:0] rec_clra [0:NCYC];
    logic [32:0]       rec_out  [0:NCYC];

    seat_scan_reader dut (
        .clk_scan       (clk_scan),
        .rst_scan       (rst_scan),
        .start_scan     (start_scan),
        .Time_now       (Time_now),
        .limit_time     (limit_time),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_time        (rd_time),
        .rd_state       (rd_state),
        .busy           (busy),
        .done           (done),
        .free_cnt       (free_cnt),
        .reserved_cnt   (reserved_cnt),
        .occupied_cnt   (occupied_cnt),
        .expired_cnt    (expired_cnt),
        .first_free     (first_free),
        .first_free_vld (first_free_vld)
`ifdef SEAT_SCAN_EXPIRE_CLR_EN
        ,
        .clr_en         (clr_en),
        .clr_addr       (clr_addr)
`endif
    );

    always #5 clk_scan = ~clk_scan;

    // Seat table model: synchronous read, data valid the cycle after rd_en
    always @(posedge clk_scan) begin
        if (rd_en) begin
            rd_time  <= mem_time[rd_addr];
            rd_state <= mem_state[rd_addr];
        end
    end

    function automatic logic [32:0] outv();
        return {free_cnt, reserved_cnt, occupied_cnt, expired_cnt, first_free, first_free_vld};
    endfunction

    function automatic logic [32:0] pack(int f, int r, int o, int e, int ff, bit v);
        return {CNT_W'(f), CNT_W'(r), CNT_W'(o), CNT_W'(e), SEAT_W'(ff), v};
    endfunction

    // Number of cycles deviating from the nominal scan timeline
    function automatic int pattern_bad();
        int b = 0;
        for (int c = 1; c <= NCYC; c++) begin
            if (rec_rden[c] !== (c <= 32)) b++;
            if (c <= 32 && rec_addr[c] !== SEAT_W'(c - 1)) b++;
            if (rec_busy[c] !== (c <= 33)) b++;
            if (rec_done[c] !== (c == 34)) b++;
        end
        return b;
    endfunction

    task automatic clear_table(input logic [1:0] st);
        for (int i = 0; i < N_SEATS; i++) begin
            mem_state[i] = st;
            mem_time[i]  = '0;
        end
    endtask

    // Issue start, record NCYC cycles; optional extra start pulse / reset cycle.
    // Time_now and limit_time are disturbed mid-scan to exercise the snapshot.
    task automatic run_scan(input int pulse_c, input int rst_c);
        @(negedge clk_scan);
        start_scan = 1'b1;
        for (int c = 1; c <= NCYC; c++) begin
            @(negedge clk_scan);
            rec_rden[c] = rd_en;
            rec_addr[c] = rd_addr;
            rec_busy[c] = busy;
            rec_done[c] = done;
            rec_out[c]  = outv();
`ifdef SEAT_SCAN_EXPIRE_CLR_EN
            rec_clr[c]  = clr_en;
            rec_clra[c] = clr_addr;
`else
            rec_clr[c]  = 1'b0;
            rec_clra[c] = '0;
`endif
            if (c == 1) start_scan = 1'b0;
            if (c == 3) begin
                Time_now   = Time_now + 11'd1000;
                limit_time = '0;
            end
            if (c == pulse_c)     start_scan = 1'b1;
            if (c == pulse_c + 1) start_scan = 1'b0;
            if (c == rst_c)       rst_scan   = 1'b1;
            if (c == rst_c + 1)   rst_scan   = 1'b0;
        end
    endtask

    task automatic setup_expire();
        clear_table(FREE);
        for (int i = 0; i < 5; i++) mem_state[i] = OCCUPIED;
        mem_state[5] = RESERVED;
        mem_time[5]  = 11'd100;
    endtask

    task automatic test_reset();
        rst_scan   = 1'b1;
        start_scan = 1'b0;
        Time_now   = '0;
        limit_time = '0;
        repeat (3) @(posedge clk_scan);
        @(negedge clk_scan);
        rst_scan = 1'b0;
        checks++;
        if (outv() !== 33'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", outv(), 33'd0);
        end
        checks++;
        if ({rd_en, busy, done, rd_addr} !== 11'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got rd_en=%b busy=%b done=%b rd_addr=%0d expected all 0",
                     rd_en, busy, done, rd_addr);
        end
    endtask

    task automatic test_all_free();
        clear_table(FREE);
        Time_now = 11'd100; limit_time = 11'd50;
        run_scan(0, 0);
        checks++;
        if (pattern_bad() !== 0) begin
            errors++;
            $display("FAIL all_free_timeline: got %0d bad cycles expected 0", pattern_bad());
        end
        checks++;
        if (outv() !== pack(32, 0, 0, 0, 0, 1)) begin
            errors++;
            $display("FAIL all_free_result: got %h expected %h", outv(), pack(32, 0, 0, 0, 0, 1));
        end
    endtask

    task automatic test_expire();
        setup_expire();
        Time_now = 11'd400; limit_time = 11'd250;
        run_scan(0, 0);
        checks++;
        if (outv() !== pack(27, 0, 5, 1, 5, 1)) begin
            errors++;
            $display("FAIL expire_limit250: got %h expected %h", outv(), pack(27, 0, 5, 1, 5, 1));
        end
        Time_now = 11'd400; limit_time = 11'd300;
        run_scan(0, 0);
        checks++;
        if (outv() !== pack(26, 1, 5, 0, 6, 1)) begin
            errors++;
            $display("FAIL expire_limit300: got %h expected %h", outv(), pack(26, 1, 5, 0, 6, 1));
        end
        checks++;
        if (pattern_bad() !== 0) begin
            errors++;
            $display("FAIL expire_timeline: got %0d bad cycles expected 0", pattern_bad());
        end
    endtask

    task automatic test_wrap();
        clear_table(FREE);
        mem_state[2] = RESERVED;
        mem_time[2]  = 11'd2000;
        Time_now = 11'd50; limit_time = 11'd90;
        run_scan(0, 0);
        checks++;
        if (outv() !== pack(32, 0, 0, 1, 0, 1)) begin
            errors++;
            $display("FAIL wrap_limit90: got %h expected %h", outv(), pack(32, 0, 0, 1, 0, 1));
        end
        Time_now = 11'd50; limit_time = 11'd98;
        run_scan(0, 0);
        checks++;
        if (outv() !== pack(31, 1, 0, 0, 0, 1)) begin
            errors++;
            $display("FAIL wrap_limit98: got %h expected %h", outv(), pack(31, 1, 0, 0, 0, 1));
        end
    endtask

    task automatic test_all_occupied();
        clear_table(OCCUPIED);
        mem_state[20] = AWAY;
        Time_now = '0; limit_time = '0;
        run_scan(0, 0);
        checks++;
        if (outv() !== pack(0, 0, 32, 0, 0, 0)) begin
            errors++;
            $display("FAIL all_occupied_result: got %h expected %h", outv(), pack(0, 0, 32, 0, 0, 0));
        end
    endtask

    task automatic test_ignore_start();
        int bad;
        setup_expire();
        Time_now = 11'd400; limit_time = 11'd250;
        run_scan(10, 0);
        checks++;
        if (pattern_bad() !== 0) begin
            errors++;
            $display("FAIL ignore_start_timeline: got %0d bad cycles expected 0", pattern_bad());
        end
        bad = 0;
        for (int c = 1; c <= 33; c++)
            if (rec_out[c] !== pack(0, 0, 32, 0, 0, 0)) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL outputs_hold_midscan: got %0d changed cycles expected 0", bad);
        end
        checks++;
        if (outv() !== pack(27, 0, 5, 1, 5, 1)) begin
            errors++;
            $display("FAIL ignore_start_result: got %h expected %h", outv(), pack(27, 0, 5, 1, 5, 1));
        end
    endtask

    task automatic test_reset_abort();
        int ndone;
        setup_expire();
        Time_now = 11'd400; limit_time = 11'd250;
        run_scan(0, 12);
        checks++;
        if ({rec_rden[12], rec_rden[13], rec_busy[13]} !== 3'b100) begin
            errors++;
            $display("FAIL abort_rd_en: got rd_en12=%b rd_en13=%b busy13=%b expected 1 0 0",
                     rec_rden[12], rec_rden[13], rec_busy[13]);
        end
        checks++;
        if (rec_out[13] !== 33'd0) begin
            errors++;
            $display("FAIL abort_outputs: got %h expected %h", rec_out[13], 33'd0);
        end
        ndone = 0;
        for (int c = 1; c <= NCYC; c++)
            if (rec_done[c] === 1'b1) ndone++;
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses expected 0", ndone);
        end
        Time_now = 11'd400; limit_time = 11'd250;
        run_scan(0, 0);
        checks++;
        if (pattern_bad() !== 0) begin
            errors++;
            $display("FAIL after_abort_timeline: got %0d bad cycles expected 0", pattern_bad());
        end
        checks++;
        if (outv() !== pack(27, 0, 5, 1, 5, 1)) begin
            errors++;
            $display("FAIL after_abort_result: got %h expected %h", outv(), pack(27, 0, 5, 1, 5, 1));
        end
    endtask

`ifdef SEAT_SCAN_EXPIRE_CLR_EN
    task automatic test_clear();
        int bad;
        clear_table(FREE);
        mem_state[3] = RESERVED;
        mem_state[7] = RESERVED;
        Time_now = 11'd500; limit_time = 11'd100;
        run_scan(0, 0);
        bad = 0;
        for (int c = 1; c <= NCYC; c++) begin
            if (rec_clr[c] !== (c == 6 || c == 10)) bad++;
            if (c == 6  && rec_clra[c] !== SEAT_W'(3)) bad++;
            if (c == 10 && rec_clra[c] !== SEAT_W'(7)) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL clear_pulses: got %0d bad cycles expected 0", bad);
        end
        checks++;
        if (outv() !== pack(32, 0, 0, 2, 0, 1)) begin
            errors++;
            $display("FAIL clear_result: got %h expected %h", outv(), pack(32, 0, 0, 2, 0, 1));
        end
        mem_state[31] = RESERVED;
        Time_now = 11'd500; limit_time = 11'd100;
        run_scan(0, 0);
        checks++;
        if ({rec_clr[34], rec_done[34], rec_clra[34]} !== {2'b11, SEAT_W'(31)}) begin
            errors++;
            $display("FAIL clear_last_seat: got clr=%b done=%b addr=%0d expected 1 1 31",
                     rec_clr[34], rec_done[34], rec_clra[34]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_all_free();
        test_expire();
        test_wrap();
        test_all_occupied();
        test_ignore_start();
        test_reset_abort();
`ifdef SEAT_SCAN_EXPIRE_CLR_EN
        test_clear();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
